// File: rtl/mul256_op_ahb_if.sv
// AHB-Lite slave front end for the mul256 operand store.
// Turns 32-bit AHB-Lite transfers into single-word bus_* requests, stalls
// with hreadyout=0 until the store answers with bus_ready, and rejects
// non-word, unaligned and word-8 write transfers with a two-cycle ERROR.
module mul256_op_ahb_if #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 hsel,
  input  logic [11:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic [9:0]           bus_addr,
  output logic [31:0]          bus_wdata,
  output logic                 bus_write,
  output logic                 bus_read,
  input  logic [31:0]          bus_rdata,
  input  logic                 bus_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [9:0]             bus_addr_q, bus_addr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic accept;
  logic illegal;
  logic can_take;
  logic err_inc;

  // Next-state, address capture and error counting for the current cycle.
  always_comb begin
    accept     = hsel & htrans[1] & hready;
    // word 8 lives at haddr[5]=1; the store cannot take writes there
    illegal    = (hsize != 3'b010) | (haddr[1:0] != 2'b00) | (hwrite & haddr[5]);
    // a new address phase may be accepted only when our data phase ends now
    can_take   = (state_q == S_IDLE) | (state_q == S_ERR2) |
                 (((state_q == S_WR) | (state_q == S_RD)) & bus_ready);
    err_inc    = can_take & accept & illegal;
    state_d    = state_q;
    bus_addr_d = bus_addr_q;
    err_cnt_d  = err_cnt_q;
    if (can_take) begin
      if (accept) begin
        bus_addr_d = haddr[11:2];
        if (illegal)     state_d = S_ERR1;
        else if (hwrite) state_d = S_WR;
        else             state_d = S_RD;
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end
    if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  // State, captured address and error counter; reset drops any request at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      bus_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bus_addr_q <= bus_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Requests decode straight from the state flops; ready follows the store.
  always_comb begin
    bus_write = (state_q == S_WR);
    bus_read  = (state_q == S_RD);
    hresp     = (state_q == S_ERR1) | (state_q == S_ERR2);
    if ((state_q == S_WR) || (state_q == S_RD)) hreadyout = bus_ready;
    else                                        hreadyout = (state_q != S_ERR1);
  end

  assign bus_addr  = bus_addr_q;
  assign err_cnt   = err_cnt_q;
  assign hrdata    = bus_rdata;
  assign bus_wdata = hwdata;

endmodule

// File: doc/mul256_op_ahb_if.md
# mul256_op_ahb_if

AHB-Lite slave front end for the mul256 operand memory. Converts 32-bit AHB-Lite transfers into the single-word bus_* request/ready protocol of the 64 × 260-bit operand store, inserts wait states until the store grants access, and rejects illegal transfers with a two-cycle ERROR response. The store supports no byte writes and no writes to word 8, so the block enforces word-only accesses and read-only word 8.

## Interface
- ERR_CNT_W, 8, width of saturating error counter

- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- hsel  in  1  AHB slave select
- haddr  in  12  byte address; [11:6] entry, [5:2] word, [1:0] must be 0
- htrans  in  2  AHB transfer type; only NONSEQ/SEQ (htrans[1]=1) start a transfer
- hwrite  in  1  1 = write
- hsize  in  3  must be 3'b010 (word)
- hwdata  in  32  write data, data phase
- hready  in  1  bus-wide HREADY
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  32  read data, valid when hreadyout=1 in a read data phase
- bus_addr  out  10  registered haddr[11:2]
- bus_wdata  out  32  = hwdata (pass-through)
- bus_write  out  1  write request, held until bus_ready
- bus_read  out  1  read request, held until bus_ready
- bus_rdata  in  32  store read data, valid in bus_ready cycle
- bus_ready  in  1  store completion strobe (registered in store)
- err_cnt  out  ERR_CNT_W  count of ERROR responses, saturates at all-ones

## Operation
- Accept: address phase qualified when hsel & htrans[1] & hready. Capture haddr[11:2] into bus_addr, plus hwrite.
- Legality at accept: ERROR if hsize≠3'b010, haddr[1:0]≠0, or (hwrite & haddr[5]=1). Reads with haddr[5]=1 are legal; the store returns {28'd0, top nibble}.
- States: IDLE, WR, RD, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0, no request. Legal write accept → WR. Legal read accept → RD. Illegal accept → ERR1. Otherwise stay.
  - WR: bus_write=1, hreadyout=bus_ready. On bus_ready, the store writes hwdata to the word. Then apply the accept rules for the next transfer, or go to IDLE.
  - RD: bus_read=1, hreadyout=bus_ready, hrdata=bus_rdata. On bus_ready, same exit rules as WR.
  - ERR1: hreadyout=0, hresp=1, no request → ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept is honoured per the IDLE rules; otherwise → IDLE.
- An illegal transfer never asserts bus_write or bus_read.
- bus_addr updates only at accept. It is held through the whole data phase, including the bus_ready cycle.
- bus_write and bus_read are never both 1.
- Non-selected or IDLE/BUSY htrans: no action, OKAY with zero wait states.
- err_cnt increments by 1 on entry to ERR1 and holds at 2^ERR_CNT_W−1.

## Timing
- Reset values: hreadyout=1, hresp=0, bus_write=0, bus_read=0, bus_addr=0, err_cnt=0, state IDLE. hrdata and bus_wdata are pass-through only.
- Reset is asynchronous at any time, including mid-transfer. It drops the request immediately and returns to IDLE, and no write completes afterwards.
- Uncontended access: accept at T0, request at T1 (hreadyout=0), bus_ready at T2 (hreadyout=1). This is one wait state per transfer.
- Back-to-back transfers: request stays high across the boundary. The store re-arms after one idle-ready cycle, so each transfer costs 2 cycles and the address switches at the T2 edge.
- Store held by the operand-side writer: bus_ready stays low. The block waits indefinitely, keeps its request asserted, and keeps hreadyout=0.
- ERROR costs exactly 2 data-phase cycles.

## Test plan
- Write 0xDEADBEEF to haddr 0x044 (entry 1, word 1), then read it back. Required: bus_write high for 2 cycles, bus_addr=0x011, one wait state each, read returns 0xDEADBEEF, hresp=0.
- Back-to-back SEQ writes to words 0..7 of entry 3, then 8 reads. Required: 2 cycles per transfer, no dropped or duplicated bus_ready, data matches.
- Write to haddr 0x020 (word 8), then a byte write (hsize=0) to 0x000, then an unaligned read at 0x002. Required: three ERR1/ERR2 pairs, no bus_write/bus_read pulses, err_cnt=3, word 0 unchanged.
- Read haddr 0x020 after the operand side wrote op_wdata[259:256]=4'hA. Required: hrdata=0x0000000A, OKAY.
- Operand side holds the store for 5 cycles during a write. Required: hreadyout=0 for 6 cycles, then completes with correct data.
- Assert rstn=0 in the WR wait cycle. Required: bus_write drops asynchronously, target word unchanged, all outputs at reset values.
- Force 300 errors. Required: err_cnt saturates at 255.
